// File: rtl/ram_read_checker.sv
// Read-side RAM checker: sweeps the read port over NUM_WORDS addresses and
// compares each returned word against address + PATTERN_BASE.
module ram_read_checker #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 16,
    parameter int NUM_WORDS    = 512,
    parameter int RD_LATENCY   = 1,
    parameter int PATTERN_BASE = 0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // One spare bit so the address+base sum never overflows before truncation.
    localparam int                SUM_W     = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [SUM_W-1:0]  BASE_EXT  = SUM_W'(PATTERN_BASE);

    logic [1:0]            state;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [ADDR_W-1:0]     pipe_addr [RD_LATENCY];
    logic [SUM_W-1:0]      expected_sum;
    logic [DATA_W-1:0]     expected_data;
    logic                  mismatch;

    always_comb begin
        expected_sum  = SUM_W'(pipe_addr[RD_LATENCY-1]) + BASE_EXT;
        expected_data = expected_sum[DATA_W-1:0];
        mismatch      = pipe_valid[RD_LATENCY-1] && (ram_rd_data != expected_data);
    end

    // Tracks each issued read until its data returns from the RAM.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
            pipe_valid[0] <= ram_rd_en;
            pipe_addr[0]  <= ram_rd_addr;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_rd_addr    <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;

            if (mismatch) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (err_cnt == 16'd0) begin
                    first_err_addr <= pipe_addr[RD_LATENCY-1];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= READ;
                        busy           <= 1'b1;
                        ram_rd_en      <= 1'b1;
                        ram_rd_addr    <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                    end
                end
                READ: begin
                    if (ram_rd_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        ram_rd_en <= 1'b0;
                    end else begin
                        ram_rd_addr <= ram_rd_addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (pipe_valid == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_cnt == 16'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_read_checker.md
Name: ram_read_checker

Overview:
- Read-side companion to the RAM write/test sequencer.
- After a start pulse, it sweeps the read port of a simple dual-port block RAM over NUM_WORDS addresses.
- It compares each returned word against the pattern the writer deposits (data = address + PATTERN_BASE).
- It reports the error count, the first failing address, pass/fail and a done pulse, so the board demo self-checks without a logic analyser.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 16, RAM data width.
- NUM_WORDS, 512, words checked; legal range 1..2**ADDR_W.
- RD_LATENCY, 1, RAM read latency in clocks from the rd_en/addr sample edge to data valid; legal range 1..3.
- PATTERN_BASE, 0, constant added to the address to form the expected data.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a check pass.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- pass  out  1  high when the last completed pass had zero errors.
- err_cnt  out  16  mismatches in the current or last pass; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch in the pass.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM read data.

Behaviour:
- Reset (rst sampled high):
  - busy, done, pass, ram_rd_en = 0.
  - ram_rd_addr = 0, err_cnt = 0, first_err_addr = 0.
  - State goes to IDLE and the read-valid pipeline is cleared.
  - This applies from any state, including mid-pass; no compare occurs in the cycle after reset.
- Clock and reset: one clock domain; reset is synchronous and active-high; ports are named sys_clk and rst.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start=1, go to READ.
  - Clear err_cnt, first_err_addr and pass.
  - Set busy=1.
  - Drive ram_rd_en=1 with ram_rd_addr=0 from the next cycle.
- READ:
  - ram_rd_en=1 every cycle; ram_rd_addr increments by 1 per cycle, from 0 to NUM_WORDS-1.
  - Exactly NUM_WORDS consecutive read cycles, with no bubbles.
  - After the NUM_WORDS-1 read cycle: go to DRAIN, ram_rd_en=0, ram_rd_addr held at its last value.
- Compare pipeline:
  - Each issued read pushes {valid, addr} into a shift register of length RD_LATENCY.
  - When the tail is valid, ram_rd_data is compared with (addr + PATTERN_BASE) truncated to DATA_W.
  - The compare takes effect at the edge RD_LATENCY cycles after the RAM sampled that read.
- On mismatch:
  - err_cnt increments, holding at 16'hFFFF with no wrap.
  - If err_cnt was 0, first_err_addr captures the tail address.
- DRAIN:
  - Wait until the pipeline is empty, i.e. the final compare has been applied.
  - Then go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass = (err_cnt == 0).
  - Next state is IDLE.
- Total timing: done is high for exactly one cycle, N+RD_LATENCY+2 cycles after the start sample edge, with N = NUM_WORDS.
- Result hold: err_cnt, first_err_addr and pass hold their values until the next accepted start or reset.
- start while busy=1 or in DONE: ignored, with no restart and no queuing.
- start in the IDLE cycle directly after DONE: accepted normally.
- NUM_WORDS=1: a single read at address 0; DRAIN still waits the full RD_LATENCY.
- Address/data width: the address counter is ADDR_W bits. The expected-data sum is computed in max(ADDR_W, DATA_W)+1 bits and truncated to DATA_W, so the expected value wraps modulo 2**DATA_W.
- Simultaneous rst and start: rst wins.

Test Plan:
1. Clean RAM: preload mem[a]=a for a=0..511, pulse start once.
   - ram_rd_en high for exactly 512 cycles, addresses 0..511 in order.
   - done pulses once, 515 cycles after start (RD_LATENCY=1).
   - err_cnt=0, pass=1, first_err_addr=0.
2. Injected faults: preload as in scenario 1, then corrupt mem[37]=16'hDEAD and mem[300]=0.
   - err_cnt=2, first_err_addr=37, pass=0.
3. Latency and base: RD_LATENCY=3, PATTERN_BASE=16'h0100, NUM_WORDS=16, mem[a]=a+16'h0100.
   - err_cnt=0, pass=1.
   - done 16+3+2=21 cycles after start.
4. Reset mid-pass: assert rst for 1 cycle at read cycle 200 of a clean 512-word pass.
   - Next cycle: busy=0, ram_rd_en=0, ram_rd_addr=0, err_cnt=0, no done pulse.
   - A new start then completes with pass=1.
5. Start ignored while busy: pulse start again at read cycles 10 and 511.
   - Address sequence and timing are unchanged and only one done pulse occurs.
   - A start one cycle after done begins a second pass.
6. Saturation and wrap: ADDR_W=4, DATA_W=4, NUM_WORDS=16, PATTERN_BASE=15.
   - Expected data is (a+15) mod 16; with mem filled correctly, pass=1.
   - Fill mem with all-wrong values with err_cnt preset near 16'hFFFE via a force: the count holds at 16'hFFFF.
